// File: rtl/cdc_pulse_rx_multi.sv
// Multi-channel toggle/level pulse receiver: per-channel synchroniser, edge detect,
// saturating pending counter with valid/ready drain. Optional glitch filter: CDC_PULSE_RX_FILTER_EN.
module cdc_pulse_rx_multi #(
  parameter int NUM_CH      = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 3,
  parameter int MODE        = 0,
  parameter int FILT_LEN    = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       async_in,
  output logic [NUM_CH-1:0]       evt_valid,
  input  logic [NUM_CH-1:0]       evt_ready,
  output logic [NUM_CH*CNT_W-1:0] evt_pend,
  output logic [NUM_CH-1:0]       ovf,
  input  logic                    ovf_clr
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_last;
    logic                   filt_val;
    logic                   prev_q;
    logic                   edge_det;
    logic                   accept;
    logic                   ovf_set;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_nxt;
    logic                   valid_q;
    logic                   ovf_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sync_q <= '0;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], async_in[ch]};
      end
    end

    assign sync_last = sync_q[SYNC_STAGES-1];

`ifdef CDC_PULSE_RX_FILTER_EN
    localparam int FW = $clog2(FILT_LEN + 1);
    logic [FW-1:0] filt_cnt_q;
    logic          filt_q;

    // The filtered level only follows the synchroniser after FILT_LEN consecutive
    // cycles of disagreement; any return to agreement restarts the count.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        filt_q     <= 1'b0;
        filt_cnt_q <= '0;
      end else if (sync_last != filt_q) begin
        if (filt_cnt_q == FW'(FILT_LEN - 1)) begin
          filt_q     <= sync_last;
          filt_cnt_q <= '0;
        end else begin
          filt_cnt_q <= filt_cnt_q + FW'(1);
        end
      end else begin
        filt_cnt_q <= '0;
      end
    end

    assign filt_val = filt_q;
`else
    logic unused_filt_len;
    assign unused_filt_len = ^FILT_LEN;
    assign filt_val        = sync_last;
`endif

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        prev_q <= 1'b0;
      end else begin
        prev_q <= filt_val;
      end
    end

    if (MODE == 0) begin : g_toggle
      assign edge_det = filt_val ^ prev_q;
    end else begin : g_level
      assign edge_det = filt_val & ~prev_q;
    end

    assign accept = valid_q & evt_ready[ch];

    // Simultaneous event and accept cancel out, which also keeps a saturated
    // counter from flagging overflow when the consumer frees a slot that cycle.
    always_comb begin
      cnt_nxt = cnt_q;
      ovf_set = 1'b0;
      if (edge_det && !accept) begin
        if (cnt_q == CNT_MAX) begin
          ovf_set = 1'b1;
        end else begin
          cnt_nxt = cnt_q + CNT_W'(1);
        end
      end else if (!edge_det && accept) begin
        cnt_nxt = cnt_q - CNT_W'(1);
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt_q   <= '0;
        valid_q <= 1'b0;
        ovf_q   <= 1'b0;
      end else begin
        cnt_q   <= cnt_nxt;
        valid_q <= (cnt_nxt != '0);
        if (ovf_set) begin
          ovf_q <= 1'b1;
        end else if (ovf_clr) begin
          ovf_q <= 1'b0;
        end
      end
    end

    assign evt_valid[ch]                = valid_q;
    assign ovf[ch]                      = ovf_q;
    assign evt_pend[ch*CNT_W +: CNT_W]  = cnt_q;
  end

endmodule

// File: doc/cdc_pulse_rx_multi.md
# cdc_pulse_rx_multi

Multi-channel receive side of the toggle-based pulse crossing. Each channel takes an asynchronous toggle (or level) line from a foreign clock domain and synchronises it into `clk` through a parametrised flop chain. Every detected edge becomes one queued event, held in a per-channel saturating pending counter and released through a valid/ready handshake. The block sits at the destination-domain boundary and replaces the single-channel 3-flop XOR receivers.

## Interface
Parameters:
- NUM_CH, 4 — number of independent channels (≥1)
- SYNC_STAGES, 2 — synchroniser depth per channel (≥2)
- CNT_W, 3 — pending-counter width; max pending = 2^CNT_W−1
- MODE, 0 — 0: toggle mode, any edge is an event; 1: level mode, rising edge only
- FILT_LEN, 3 — glitch-filter length in cycles (≥1); used only with the filter macro

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  destination clock
- rst  in  1  asynchronous active-high reset
- async_in  in  NUM_CH  asynchronous source lines, one per channel
- evt_valid  out  NUM_CH  channel has ≥1 pending event
- evt_ready  in  NUM_CH  consumer accepts one event on channel i
- evt_pend  out  NUM_CH*CNT_W  pending count; channel i at [i*CNT_W +: CNT_W]
- ovf  out  NUM_CH  sticky: an event was dropped at a saturated counter
- ovf_clr  in  1  clears all ovf bits

## Operation
- Per channel: sync[0..SYNC_STAGES-1], then prev register; all reset to 0.
- Edge detect: MODE 0: `sync[last] ^ prev`; MODE 1: `sync[last] & ~prev`. prev <= sync[last] every cycle.
- Pending counter cnt[i], reset 0; evt_valid[i] = (cnt[i] != 0); evt_pend mirrors cnt.
- Accept = evt_valid[i] & evt_ready[i]; evt_ready with cnt=0 is ignored (no underflow).
- Update per cycle: event only → cnt+1; accept only → cnt−1; event and accept → unchanged.
- Event with cnt = max and no accept → cnt holds at max, ovf[i] set. Event + accept at max → unchanged, no ovf.
- ovf_clr clears all ovf bits; a same-cycle ovf set on channel i wins over clear.
- Channels fully independent; no arbitration.
- Source constraint (documented, not checked): consecutive source toggles are ≥ SYNC_STAGES+1 `clk` periods apart (plus FILT_LEN with the filter). Closer toggles may merge and are lost silently.

## Timing
- Reset: evt_valid=0, evt_pend=0, ovf=0; sync, prev and filter state 0. Reset asserted mid-operation discards all pending events immediately (async).
- If async_in is high at reset release in MODE 0/1, one event is produced after the sync latency. This is intended: the source must also reset low.
- Latency: change captured at edge 1 → sync[last] valid at edge SYNC_STAGES → cnt/evt_valid updated at edge SYNC_STAGES+1. Default is 3 cycles, with ±1 cycle uncertainty from the asynchronous capture.
- Handshake: an accept at edge k is reflected in cnt/evt_valid after edge k. Back-to-back accepts drain 1 event per cycle.
- All outputs are registered; there is no combinational path from async_in.

## Configuration
- CDC_PULSE_RX_FILTER_EN defined: sync[last] must differ from the filtered value for FILT_LEN consecutive cycles before the filtered value (feeding prev/edge detect) updates. This adds FILT_LEN cycles of latency. Pulses/glitches shorter than FILT_LEN cycles produce no event; the filter counter resets to 0 on any mismatch break.
- Undefined: no filter; FILT_LEN is ignored; latency is as in Timing.

## Test plan
- Reset, NUM_CH=4, SYNC_STAGES=2: toggle async_in[0] once, ready=0 → evt_valid[0] rises 3±1 cycles later, evt_pend[0]=1, other channels 0.
- Five spaced toggles on ch1 with ready=0, then ready=1 for 6 cycles → pend counts 1..5, then drains 5→0 one per cycle; evt_valid[1] drops after the 5th accept.
- CNT_W=3, nine spaced toggles, ready=0 → pend saturates at 7, ovf[2]=1. ovf_clr pulse → ovf=0, pend stays 7.
- Event arriving in the same cycle as an accept at pend=7 → pend stays 7, ovf stays 0. ovf_clr coincident with a new overflow → ovf stays 1.
- MODE=1, async_in[3] high 10 cycles then low → exactly one event, none on the falling edge.
- Filter built, FILT_LEN=3: 2-cycle glitch → no event; 5-cycle level change → one event at latency 3+3±1.
